// File: rtl/tx_pkg.sv
// Shared constants, generator masks and FSM state type for the 802.11a bit-level transmitter.
// Optional feature macro: TX_SCRAMBLER_EN (enables the payload scrambler).
`default_nettype none

package tx_pkg;

    localparam int N_BLK  = 90;
    localparam int N_TAIL = 6;
    localparam int N_DATA = N_BLK - N_TAIL;

    localparam logic [6:0] SCR_SEED = 7'b1011101;

    // Mask bit (6-k) selects history tap u_{i-k}.
    localparam logic [6:0] G0 = 7'o133;
    localparam logic [6:0] G1 = 7'o171;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } tx_state_t;

    function automatic logic [6:0] clamp_pad(input logic [5:0] n);
        if ({1'b0, n} > 7'(N_DATA)) begin
            return 7'(N_DATA);
        end
        return {1'b0, n};
    endfunction

endpackage

`default_nettype wire

// File: rtl/conv_enc_k7.sv
// Rate-1/2, K=7 convolutional encoder core: combinational A/B outputs over a 6-bit history.
`default_nettype none

module conv_enc_k7
    import tx_pkg::*;
(
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    input  logic u_i,
    output logic a_o,
    output logic b_o
);

    // sr_q[5] = u_{i-1} ... sr_q[0] = u_{i-6}
    logic [5:0] sr_q;
    logic [5:0] sr_d;
    logic [6:0] win;

    always_comb begin
        win  = {u_i, sr_q};
        a_o  = ^(win & G0);
        b_o  = ^(win & G1);
        sr_d = {u_i, sr_q[5:1]};
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sr_q <= '0;
        end else if (clr_i) begin
            sr_q <= '0;
        end else if (en_i) begin
            sr_q <= sr_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/transmitter.sv
// 802.11a transmit front end: serial payload + pad, optional scrambling, zero tail, K=7 rate-1/2 encoding.
// Optional feature macro: TX_SCRAMBLER_EN.
`default_nettype none

module transmitter
    import tx_pkg::*;
(
    input  logic                 Clk,
    input  logic                 reset,
    input  logic                 data_in,
    input  logic [5:0]           n_pad,
    output logic [2*N_BLK-1:0]   data_out,
    output logic                 ready
);

    localparam logic [6:0] LAST_IDX = 7'(N_BLK - 1);

    tx_state_t          state_q;
    logic [6:0]         cnt_q;
    logic [6:0]         cnt_d;
    logic [6:0]         pad_q;
    logic [6:0]         pad_d;
    logic [6:0]         len;
    logic [2*N_BLK-1:0] data_out_q;
    logic               ready_q;
    logic               x_bit;
    logic               u_bit;
    logic               enc_a;
    logic               enc_b;
    logic               enc_en;
    logic               enc_clr;
`ifdef TX_SCRAMBLER_EN
    logic [6:0]         scr_q;
    logic [6:0]         scr_d;
    logic               fb;
`endif

    always_comb begin
        // The pad count is taken live on the first edge, then held for the block.
        pad_d = (state_q == IDLE) ? clamp_pad(n_pad) : pad_q;
        len   = 7'(N_DATA) - pad_d;
        x_bit = (cnt_q < len) ? data_in : 1'b0;
        cnt_d = cnt_q + 7'd1;
`ifdef TX_SCRAMBLER_EN
        fb    = scr_q[6] ^ scr_q[3];
        scr_d = (cnt_q < 7'(N_DATA)) ? {scr_q[5:0], fb} : scr_q;
        u_bit = (cnt_q < 7'(N_DATA)) ? (x_bit ^ fb) : 1'b0;
`else
        u_bit = (cnt_q < 7'(N_DATA)) ? x_bit : 1'b0;
`endif
        enc_en  = (state_q != DONE);
        enc_clr = (state_q == DONE);
    end

    conv_enc_k7 u_enc (
        .clk_i (Clk),
        .rst_i (reset),
        .clr_i (enc_clr),
        .en_i  (enc_en),
        .u_i   (u_bit),
        .a_o   (enc_a),
        .b_o   (enc_b)
    );

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            pad_q      <= '0;
            data_out_q <= '0;
            ready_q    <= 1'b0;
`ifdef TX_SCRAMBLER_EN
            scr_q      <= SCR_SEED;
`endif
        end else begin
            case (state_q)
                IDLE, RUN: begin
                    pad_q <= pad_d;
                    cnt_q <= cnt_d;
                    data_out_q[{cnt_q, 1'b0} +: 2] <= {enc_b, enc_a};
`ifdef TX_SCRAMBLER_EN
                    scr_q <= scr_d;
`endif
                    if (cnt_q == LAST_IDX) begin
                        state_q <= DONE;
                        ready_q <= 1'b1;
                    end else begin
                        state_q <= RUN;
                    end
                end
                DONE: begin
                    state_q <= DONE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign data_out = data_out_q;
    assign ready    = ready_q;

endmodule

`default_nettype wire

// File: tb/tb_transmitter.sv
// Self-checking bench for transmitter: golden block model feeding a scoreboard queue.
`default_nettype none

module tb_transmitter;

    localparam int NB = 90;
    localparam int ND = 84;

    logic         Clk;
    logic         reset;
    logic         data_in;
    logic [5:0]   n_pad;
    logic [179:0] data_out;
    logic         ready;

    int n_vec = 0;
    int n_err = 0;

    logic [179:0] sb_q[$];
    logic [179:0] exp_w;
    logic [179:0] frozen;
    logic [83:0]  pat;

    transmitter dut (
        .Clk      (Clk),
        .reset    (reset),
        .data_in  (data_in),
        .n_pad    (n_pad),
        .data_out (data_out),
        .ready    (ready)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

`define CHK(tag, obs, expv) \
    begin \
        n_vec++; \
        assert ((obs) === (expv)) else begin \
            n_err++; \
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv); \
        end \
    end

    // Direct reading of the block equations: history h[k] = u_{i-k}.
    function automatic logic [179:0] model(input logic [83:0] p, input int np);
        logic [179:0] r;
        logic [6:0]   s;
        logic [6:0]   h;
        logic         x;
        logic         u;
        logic         f;
        int           padc;
        int           len;
        r    = '0;
        s    = 7'b1011101;
        h    = '0;
        padc = (np > ND) ? ND : np;
        len  = ND - padc;
        for (int i = 0; i < NB; i++) begin
            x = (i < len) ? p[i] : 1'b0;
            u = x;
`ifdef TX_SCRAMBLER_EN
            if (i < ND) begin
                f = s[6] ^ s[3];
                u = x ^ f;
                s = {s[5:0], f};
            end
`else
            f = 1'b0;
`endif
            if (i >= ND) u = 1'b0;
            h = {h[5:0], u};
            r[2*i]   = h[0] ^ h[2] ^ h[3] ^ h[5] ^ h[6];
            r[2*i+1] = h[0] ^ h[1] ^ h[2] ^ h[3] ^ h[6];
        end
        return r;
    endfunction

    // Entered at a negedge with reset low; leaves at the negedge after the last edge.
    task automatic run_edges(input logic [83:0] p, input logic [5:0] np, input int n);
        n_pad = np;
        for (int k = 0; k < n; k++) begin
            data_in = (k < ND) ? p[k] : 1'($urandom);
            @(posedge Clk);
            @(negedge Clk);
            n_pad = 6'($urandom);
            if (k < NB - 1) `CHK("ready_early", ready, 1'b0)
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #2;
        `CHK("rst_data", data_out, 180'b0)
        `CHK("rst_ready", ready, 1'b0)
        @(negedge Clk);
        reset = 1'b0;
    endtask

    task automatic full_block(input logic [83:0] p, input logic [5:0] np);
        sb_q.push_back(model(p, int'(np)));
        run_edges(p, np, NB);
        `CHK("ready_90", ready, 1'b1)
        if (sb_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL scoreboard: observed empty queue expected one entry");
        end else begin
            exp_w = sb_q.pop_front();
            `CHK("block", data_out, exp_w)
        end
    endtask

    initial begin
        reset   = 1'b1;
        data_in = 1'b0;
        n_pad   = 6'd0;
        #12;
        do_reset();

        // All-zero payload, no pad.
        full_block(84'b0, 6'd0);
`ifdef TX_SCRAMBLER_EN
        `CHK("scr_zero_low6", data_out[5:0], 6'b011100)
`else
        `CHK("zero_block", data_out, 180'b0)
`endif

        // Single leading one.
        do_reset();
        full_block(84'b1, 6'd0);
`ifndef TX_SCRAMBLER_EN
        `CHK("impulse_low14", data_out[13:0], 14'b11010011111011)
        `CHK("impulse_rest", data_out[179:14], 166'b0)
`endif

        // Maximum pad, all-ones payload.
        do_reset();
        full_block({84{1'b1}}, 6'd63);
`ifndef TX_SCRAMBLER_EN
        `CHK("pad63_flush", data_out[179:54], 126'b0)
`endif

        // Abort mid-block, then a clean run of a different pattern.
        do_reset();
        pat = {20'($urandom), 32'($urandom), 32'($urandom)};
        run_edges(pat, 6'd63, 40);
        reset = 1'b1;
        #2;
        `CHK("abort_data", data_out, 180'b0)
        `CHK("abort_ready", ready, 1'b0)
        @(negedge Clk);
        reset = 1'b0;
        pat = {20'($urandom), 32'($urandom), 32'($urandom)};
        full_block(pat, 6'd5);

        // Outputs frozen after completion.
        frozen = model(pat, 5);
        for (int k = 0; k < 50; k++) begin
            data_in = 1'($urandom);
            n_pad   = 6'($urandom);
            @(posedge Clk);
            @(negedge Clk);
            `CHK("hold_data", data_out, frozen)
            `CHK("hold_ready", ready, 1'b1)
        end

        // A few random blocks with random pad counts.
        for (int b = 0; b < 3; b++) begin
            do_reset();
            pat = {20'($urandom), 32'($urandom), 32'($urandom)};
            full_block(pat, 6'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

`undef CHK

endmodule

`default_nettype wire
